// File: rtl/dma_cpu_reg_if_if.sv
// CPU I/O bus bundle for the DMA register interface: chip select, read/write
// strobes, 4-bit register address and the 8-bit data bus in both directions.
interface dma_cpu_reg_if_if;
  logic       cs_n;
  logic       ior_n;
  logic       iow_n;
  logic [3:0] a;
  logic [7:0] db_in;
  logic [7:0] db_out;
  logic       db_oe;

  modport master (output cs_n, ior_n, iow_n, a, db_in, input db_out, db_oe);
  modport slave  (input cs_n, ior_n, iow_n, a, db_in, output db_out, db_oe);
endinterface

// File: rtl/dma_cpu_reg_if.sv
// dma_cpu_reg_if: CPU programming port of the 4-channel 8237A-style DMA
// controller. Holds command/mode/request/mask/base registers, tc flags and the
// byte-pointer flip-flop, and returns status/temp (and optionally current
// address/count) to the CPU.
// Optional feature macro: DMA_ADDR_READBACK_EN -- reads of addresses 0-7
// return the current address/count byte chosen by the byte pointer and toggle it.
module dma_cpu_reg_if (
  input  logic        clk,
  input  logic        reset,
  dma_cpu_reg_if_if.slave bus,
  input  logic        dma_active,
  input  logic [63:0] cur_addr_in,
  input  logic [63:0] cur_count_in,
  input  logic [3:0]  tc_in,
  input  logic [3:0]  dreq_in,
  input  logic [7:0]  temp_in,
  output logic [7:0]  cmd_reg,
  output logic [23:0] mode_reg,
  output logic [3:0]  mask_reg,
  output logic [3:0]  req_reg,
  output logic [63:0] base_addr,
  output logic [63:0] base_count,
  output logic [3:0]  cur_load,
  output logic        master_clr
);

  logic        iow_q, ior_q, cs_q;
  logic [3:0]  a_q;
  logic        rd_ok_q, abort_q;
  logic        bp_q, bp_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [23:0] mode_q, mode_d;
  logic [3:0]  mask_q, mask_d;
  logic [3:0]  req_q, req_d;
  logic [3:0]  tcf_q, tcf_d;
  logic [63:0] base_addr_q, base_addr_d;
  logic [63:0] base_count_q, base_count_d;
  logic [3:0]  cur_load_q, cur_load_d;
  logic        mclr_q, mclr_d;

  logic        rd_cond, wr_commit, rd_trail;
  logic [7:0]  rd_mux;
  logic [1:0]  sel, wch;
  logic [5:0]  woff;

  // A read is live only with a single strobe and the CPU owning the bus.
  assign rd_cond   = !reset && !bus.cs_n && !bus.ior_n && bus.iow_n && !dma_active;
  // Commit only on the first cycle of a write strobe, so one commit per assertion.
  assign wr_commit = !bus.cs_n && !bus.iow_n && bus.ior_n && iow_q && !dma_active;
  // Trailing edge of a read that was never interrupted by the core.
  assign rd_trail  = !ior_q && bus.ior_n && !cs_q && rd_ok_q && !abort_q && !dma_active;

  assign sel  = bus.db_in[1:0];
  assign wch  = bus.a[2:1];
  assign woff = {wch, bp_q, 3'b000};

`ifdef DMA_ADDR_READBACK_EN
  logic [5:0] roff;
  assign roff = {bus.a[2:1], bp_q, 3'b000};
`else
  logic unused_rb;
  assign unused_rb = ^{cur_addr_in, cur_count_in};
`endif

  // Read data selection from the live address.
  always_comb begin
    rd_mux = 8'h00;
    case (bus.a)
      4'h8: rd_mux = {dreq_in, tcf_q};
      4'hD: rd_mux = temp_in;
      default: begin
`ifdef DMA_ADDR_READBACK_EN
        if (!bus.a[3])
          rd_mux = bus.a[0] ? cur_count_in[roff +: 8] : cur_addr_in[roff +: 8];
`endif
      end
    endcase
  end

  assign bus.db_oe  = rd_cond;
  assign bus.db_out = rd_cond ? rd_mux : 8'h00;

  // Next-state computation for every programmable register and pulse.
  always_comb begin
    bp_d         = bp_q;
    cmd_d        = cmd_q;
    mode_d       = mode_q;
    mask_d       = mask_q;
    base_addr_d  = base_addr_q;
    base_count_d = base_count_q;
    cur_load_d   = 4'h0;
    mclr_d       = 1'b0;
    // tc set is applied after the status-read clear so a same-cycle tc wins.
    tcf_d = (rd_trail && a_q == 4'h8) ? 4'h0 : tcf_q;
    tcf_d = tcf_d | tc_in;
    // tc clear first; a same-cycle request write below overrides it.
    req_d = req_q & ~tc_in;
`ifdef DMA_ADDR_READBACK_EN
    if (rd_trail && !a_q[3])
      bp_d = ~bp_d;
`endif
    if (wr_commit) begin
      case (bus.a)
        4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
          if (bus.a[0]) base_count_d[woff +: 8] = bus.db_in;
          else          base_addr_d[woff +: 8]  = bus.db_in;
          cur_load_d[wch] = 1'b1;
          bp_d = ~bp_d;
        end
        4'h8: cmd_d = bus.db_in;
        4'h9: req_d[sel] = bus.db_in[2];
        4'hA: mask_d[sel] = bus.db_in[2];
        4'hB: begin
          for (int i = 0; i < 4; i++)
            if (sel == 2'(i)) mode_d[i*6 +: 6] = bus.db_in[7:2];
        end
        4'hC: bp_d = 1'b0;
        4'hD: begin
          mclr_d       = 1'b1;
          cmd_d        = 8'h00;
          req_d        = 4'h0;
          tcf_d        = 4'h0;
          bp_d         = 1'b0;
          mode_d       = 24'h0;
          base_addr_d  = 64'h0;
          base_count_d = 64'h0;
          mask_d       = 4'hF;
        end
        4'hE: mask_d = 4'h0;
        4'hF: mask_d = bus.db_in[3:0];
        default: ;
      endcase
    end
  end

  // State registers, bus input history and registered pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      iow_q        <= 1'b1;
      ior_q        <= 1'b1;
      cs_q         <= 1'b1;
      a_q          <= 4'h0;
      rd_ok_q      <= 1'b0;
      abort_q      <= 1'b0;
      bp_q         <= 1'b0;
      cmd_q        <= 8'h00;
      mode_q       <= 24'h0;
      mask_q       <= 4'hF;
      req_q        <= 4'h0;
      tcf_q        <= 4'h0;
      base_addr_q  <= 64'h0;
      base_count_q <= 64'h0;
      cur_load_q   <= 4'h0;
      mclr_q       <= 1'b0;
    end else begin
      iow_q        <= bus.iow_n;
      ior_q        <= bus.ior_n;
      cs_q         <= bus.cs_n;
      a_q          <= bus.a;
      rd_ok_q      <= rd_cond;
      // Any core takeover during a read strobe poisons the whole access.
      abort_q      <= bus.ior_n ? 1'b0 : (abort_q | dma_active);
      bp_q         <= bp_d;
      cmd_q        <= cmd_d;
      mode_q       <= mode_d;
      mask_q       <= mask_d;
      req_q        <= req_d;
      tcf_q        <= tcf_d;
      base_addr_q  <= base_addr_d;
      base_count_q <= base_count_d;
      cur_load_q   <= cur_load_d;
      mclr_q       <= mclr_d;
    end
  end

  assign cmd_reg    = cmd_q;
  assign mode_reg   = mode_q;
  assign mask_reg   = mask_q;
  assign req_reg    = req_q;
  assign base_addr  = base_addr_q;
  assign base_count = base_count_q;
  assign cur_load   = cur_load_q;
  assign master_clr = mclr_q;

endmodule

// File: tb/tb_dma_cpu_reg_if.sv
// Directed bench for dma_cpu_reg_if; expected values are hand-derived.
module tb_dma_cpu_reg_if;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dma_cpu_reg_if_if bus();

  logic        dma_active;
  logic [63:0] cur_addr_in, cur_count_in;
  logic [3:0]  tc_in, dreq_in;
  logic [7:0]  temp_in;
  logic [7:0]  cmd_reg;
  logic [23:0] mode_reg;
  logic [3:0]  mask_reg, req_reg, cur_load;
  logic [63:0] base_addr, base_count;
  logic        master_clr;

  dma_cpu_reg_if dut (
    .clk(clk), .reset(reset), .bus(bus), .dma_active(dma_active),
    .cur_addr_in(cur_addr_in), .cur_count_in(cur_count_in), .tc_in(tc_in),
    .dreq_in(dreq_in), .temp_in(temp_in), .cmd_reg(cmd_reg), .mode_reg(mode_reg),
    .mask_reg(mask_reg), .req_reg(req_reg), .base_addr(base_addr),
    .base_count(base_count), .cur_load(cur_load), .master_clr(master_clr)
  );

  int total = 0;
  int bad   = 0;
  logic [7:0] d;
  logic       oe;
  logic [7:0] exp_lo, exp_hi;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [3:0] ad, input logic [7:0] dat);
    @(posedge clk); #1;
    bus.cs_n = 1'b0; bus.a = ad; bus.db_in = dat; bus.iow_n = 1'b0;
    @(posedge clk); #1;
    bus.iow_n = 1'b1; bus.cs_n = 1'b1;
  endtask

  task automatic rd(input logic [3:0] ad, input logic [3:0] tc_trail,
                    output logic [7:0] dat, output logic en);
    @(posedge clk); #1;
    bus.cs_n = 1'b0; bus.a = ad; bus.ior_n = 1'b0;
    #2;
    dat = bus.db_out; en = bus.db_oe;
    @(posedge clk); #1;
    bus.ior_n = 1'b1; bus.cs_n = 1'b1; tc_in = tc_trail;
    @(posedge clk); #1;
    tc_in = 4'h0;
  endtask

  task automatic tc_pulse(input logic [3:0] v);
    @(posedge clk); #1; tc_in = v;
    @(posedge clk); #1; tc_in = 4'h0;
  endtask

  initial begin
    bus.cs_n = 1'b1; bus.ior_n = 1'b1; bus.iow_n = 1'b1; bus.a = 4'h0; bus.db_in = 8'h00;
    dma_active = 1'b0; cur_addr_in = 64'h0; cur_count_in = 64'h0;
    tc_in = 4'h0; dreq_in = 4'h0; temp_in = 8'h3C;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    chk("rst_mask", mask_reg, 4'hF);
    chk("rst_cmd", cmd_reg, 8'h00);
    chk("rst_mode", mode_reg, 24'h0);
    chk("rst_base", base_addr, 64'h0);
    chk("rst_oe", bus.db_oe, 1'b0);
    rd(4'h8, 4'h0, d, oe);
    chk("rst_status", d, 8'h00);
    chk("rst_status_oe", oe, 1'b1);

    // byte pointer starts low; cur_load pulses one cycle after each write
    wr(4'h2, 8'h34);
    chk("ch1_addr_lo", base_addr[31:16], 16'h0034);
    chk("cur_load_1a", cur_load, 4'b0010);
    @(posedge clk); #1;
    chk("cur_load_1a_end", cur_load, 4'b0000);
    wr(4'h2, 8'h12);
    chk("ch1_addr", base_addr[31:16], 16'h1234);
    chk("cur_load_1b", cur_load, 4'b0010);
    @(posedge clk); #1;
    chk("cur_load_1b_end", cur_load, 4'b0000);

    // clear byte pointer mid-pair
    wr(4'h1, 8'hAA);
    chk("ch0_cnt_lo", base_count[15:0], 16'h00AA);
    wr(4'hC, 8'h00);
    wr(4'h1, 8'h55);
    chk("bp_clear", base_count[15:0], 16'h0055);

    // current count readback of ch3
    cur_count_in = {16'hABCD, 48'h0};
    wr(4'hC, 8'h00);
`ifdef DMA_ADDR_READBACK_EN
    exp_lo = 8'hCD; exp_hi = 8'hAB;
`else
    exp_lo = 8'h00; exp_hi = 8'h00;
`endif
    rd(4'h7, 4'h0, d, oe);
    chk("rb_lo", d, exp_lo);
    rd(4'h7, 4'h0, d, oe);
    chk("rb_hi", d, exp_hi);

    rd(4'hD, 4'h0, d, oe);
    chk("temp_rd", d, 8'h3C);
    rd(4'h9, 4'h0, d, oe);
    chk("req_rd_zero", d, 8'h00);

    // request / terminal count / status
    wr(4'h9, 8'h06);
    chk("req_set", req_reg, 4'b0100);
    tc_pulse(4'b0100);
    chk("req_tc_clr", req_reg, 4'b0000);
    rd(4'h8, 4'b0010, d, oe);
    chk("status_tc2", d, 8'h04);
    dreq_in = 4'h8;
    rd(4'h8, 4'h0, d, oe);
    chk("status_tc_win", d, 8'h82);
    rd(4'h8, 4'h0, d, oe);
    chk("status_cleared", d, 8'h80);
    dreq_in = 4'h0;
    tc_in = 4'b0100;
    wr(4'h9, 8'h06);
    tc_in = 4'h0;
    chk("req_write_wins", req_reg, 4'b0100);
    rd(4'h8, 4'h0, d, oe);
    chk("status_tc2b", d, 8'h04);
    wr(4'h9, 8'h02);
    chk("req_clr_sw", req_reg, 4'b0000);

    // masks, mode, command, master clear
    wr(4'hF, 8'h05);
    chk("mask_all", mask_reg, 4'h5);
    wr(4'hA, 8'h00);
    chk("mask_single_clr", mask_reg, 4'h4);
    wr(4'hA, 8'h07);
    chk("mask_single_set", mask_reg, 4'hC);
    wr(4'hE, 8'hFF);
    chk("mask_clear_all", mask_reg, 4'h0);
    wr(4'h8, 8'h5A);
    chk("cmd_wr", cmd_reg, 8'h5A);
    wr(4'hB, 8'hA6);
    chk("mode_ch2", mode_reg, 24'h029000);
    wr(4'h0, 8'h77);
    chk("ch0_addr_lo", base_addr, 64'h0000_0000_1234_0077);
    wr(4'hD, 8'h00);
    chk("mclr_pulse", master_clr, 1'b1);
    chk("mclr_mask", mask_reg, 4'hF);
    chk("mclr_cmd", cmd_reg, 8'h00);
    chk("mclr_mode", mode_reg, 24'h0);
    chk("mclr_base", base_addr, 64'h0);
    @(posedge clk); #1;
    chk("mclr_pulse_end", master_clr, 1'b0);
    wr(4'h0, 8'h11);
    chk("mclr_bp", base_addr, 64'h11);

    // core owns the bus: accesses ignored
    wr(4'h8, 8'h5A);
    dma_active = 1'b1;
    wr(4'h8, 8'h99);
    chk("dma_wr_ignored", cmd_reg, 8'h5A);
    rd(4'h8, 4'h0, d, oe);
    chk("dma_rd_oe", oe, 1'b0);
    chk("dma_rd_data", d, 8'h00);
    dma_active = 1'b0;

    // read abandoned by dma_active rising mid-strobe keeps tc flags
    tc_pulse(4'b0001);
    @(posedge clk); #1;
    bus.cs_n = 1'b0; bus.a = 4'h8; bus.ior_n = 1'b0;
    @(posedge clk); #1;
    dma_active = 1'b1;
    @(posedge clk); #1;
    bus.ior_n = 1'b1; bus.cs_n = 1'b1;
    @(posedge clk); #1;
    dma_active = 1'b0;
    rd(4'h8, 4'h0, d, oe);
    chk("abandon_keeps_tc", d, 8'h01);
    rd(4'h8, 4'h0, d, oe);
    chk("tc_cleared_after", d, 8'h00);

    // both strobes low
    @(posedge clk); #1;
    bus.cs_n = 1'b0; bus.a = 4'h8; bus.db_in = 8'h11; bus.iow_n = 1'b0; bus.ior_n = 1'b0;
    #2;
    chk("both_low_oe", bus.db_oe, 1'b0);
    @(posedge clk); #1;
    bus.iow_n = 1'b1; bus.ior_n = 1'b1; bus.cs_n = 1'b1;
    chk("both_low_no_commit", cmd_reg, 8'h5A);

    // reset mid-read
    @(posedge clk); #1;
    bus.cs_n = 1'b0; bus.a = 4'hD; bus.ior_n = 1'b0;
    #1;
    chk("pre_rst_oe", bus.db_oe, 1'b1);
    #1 reset = 1'b1;
    #1;
    chk("midrst_oe", bus.db_oe, 1'b0);
    chk("midrst_db", bus.db_out, 8'h00);
    chk("midrst_mask", mask_reg, 4'hF);
    chk("midrst_cmd", cmd_reg, 8'h00);
    chk("midrst_base", base_addr, 64'h0);
    chk("midrst_pulses", {cur_load, master_clr}, 5'h00);
    @(posedge clk); #1;
    reset = 1'b0; bus.ior_n = 1'b1; bus.cs_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
